// File: rtl/bottom_linear_pipe.sv
// Multi-lane pipelined forward bottom linear transform of the depth-16 AES S-box:
// each lane maps M45..M62 through the L0-L29 XOR network to one S byte.
module bottom_linear_pipe #(
    parameter int LANES  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [63*LANES-1:0]  in_m,
    input  logic                 in_const_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_s,
    output logic [CNT_W-1:0]     beat_cnt
);

    // h[k] carries M(45+k); M0..M44 are not part of the bottom transform.
    function automatic logic [29:0] lin_terms(input logic [17:0] h);
        logic [29:0] l;
        l[0]  = h[15] ^ h[16];
        l[1]  = h[4]  ^ h[10];
        l[2]  = h[0]  ^ h[2];
        l[3]  = h[1]  ^ h[9];
        l[4]  = h[8]  ^ h[12];
        l[5]  = h[3]  ^ h[15];
        l[6]  = h[16] ^ l[5];
        l[7]  = h[0]  ^ l[3];
        l[8]  = h[5]  ^ h[13];
        l[9]  = h[6]  ^ h[7];
        l[10] = h[7]  ^ l[4];
        l[11] = h[14] ^ l[2];
        l[12] = h[2]  ^ h[5];
        l[13] = h[4]  ^ l[0];
        l[14] = h[6]  ^ h[15];
        l[15] = h[9]  ^ l[1];
        l[16] = h[10] ^ l[0];
        l[17] = h[11] ^ l[1];
        l[18] = h[12] ^ l[8];
        l[19] = h[17] ^ l[4];
        l[20] = l[0]  ^ l[1];
        l[21] = l[1]  ^ l[7];
        l[22] = l[3]  ^ l[12];
        l[23] = l[18] ^ l[2];
        l[24] = l[15] ^ l[9];
        l[25] = l[6]  ^ l[10];
        l[26] = l[7]  ^ l[9];
        l[27] = l[8]  ^ l[10];
        l[28] = l[11] ^ l[14];
        l[29] = l[11] ^ l[17];
        return l;
    endfunction

    // The XNOR outputs (bits 6,5,1,0) are expressed as XOR plus the 8'h63 constant.
    function automatic logic [7:0] s_byte(input logic [29:0] l, input logic c);
        logic [7:0] s;
        s[7] = l[6]  ^ l[24];
        s[6] = l[16] ^ l[26];
        s[5] = l[19] ^ l[28];
        s[4] = l[6]  ^ l[21];
        s[3] = l[20] ^ l[22];
        s[2] = l[25] ^ l[29];
        s[1] = l[13] ^ l[27];
        s[0] = l[6]  ^ l[23];
        return s ^ (c ? 8'h63 : 8'h00);
    endfunction

    // Handshake: a beat moves when valid & ready are both high at the rising edge;
    // a stage may load when it is empty or its current beat moves on in the same edge.
    logic                 v_out;
    logic                 load_out;
    logic                 src_valid;
    logic [8*LANES-1:0]   s_next;
    logic                 unused_m;

    assign load_out = ~v_out | out_ready;

    always_comb begin
        unused_m = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            unused_m = unused_m ^ (^in_m[63*i +: 45]);
        end
    end

    if (STAGES == 2) begin : g_two
        logic        v_l;
        logic        c_l;
        logic [29:0] l_q [LANES];

        assign in_ready  = ~v_l | load_out;
        assign src_valid = v_l;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v_l <= 1'b0;
                c_l <= 1'b0;
                for (int i = 0; i < LANES; i++) l_q[i] <= '0;
            end else if (in_ready) begin
                v_l <= in_valid;
                if (in_valid) begin
                    c_l <= in_const_en;
                    for (int i = 0; i < LANES; i++) l_q[i] <= lin_terms(in_m[63*i+45 +: 18]);
                end
            end
        end

        always_comb begin
            s_next = '0;
            for (int i = 0; i < LANES; i++) s_next[8*i +: 8] = s_byte(l_q[i], c_l);
        end
    end else begin : g_one
        assign in_ready  = load_out;
        assign src_valid = in_valid;

        always_comb begin
            s_next = '0;
            for (int i = 0; i < LANES; i++) begin
                s_next[8*i +: 8] = s_byte(lin_terms(in_m[63*i+45 +: 18]), in_const_en);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_out <= 1'b0;
            out_s <= '0;
        end else if (load_out) begin
            v_out <= src_valid;
            if (src_valid) out_s <= s_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) beat_cnt <= '0;
        else if (v_out && out_ready) beat_cnt <= beat_cnt + CNT_W'(1);
    end

    assign out_valid = v_out;

endmodule

// File: tb/tb_bottom_linear_pipe.sv
// Self-checking bench for bottom_linear_pipe: table vectors, hand sequences and a
// randomized run against a GF(2) matrix model of the bottom transform.
module tb_bottom_linear_pipe;

    localparam int LANES  = 4;
    localparam int STAGES = 2;
    localparam int CNT_W  = 16;
    localparam int MW     = 63*LANES;
    localparam int SW     = 8*LANES;
    localparam int NT     = 7;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [MW-1:0]    in_m;
    logic             in_const_en;
    logic             out_valid;
    logic             out_ready;
    logic [SW-1:0]    out_s;
    logic [CNT_W-1:0] beat_cnt;

    logic             s_in_valid;
    logic             s_in_ready;
    logic [62:0]      s_in_m;
    logic             s_in_const_en;
    logic             s_out_valid;
    logic             s_out_ready;
    logic [7:0]       s_out_s;
    logic [3:0]       s_beat_cnt;

    int n_vec = 0;
    int n_bad = 0;
    int exp_cnt = 0;
    logic [SW-1:0] exp_q[$];
    logic [7:0]    s_q[$];

    typedef struct {
        logic [MW-1:0] m;
        logic          c;
        logic [SW-1:0] exp;
    } vec_t;
    vec_t tbl[NT];

    bottom_linear_pipe #(.LANES(LANES), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_m(in_m), .in_const_en(in_const_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .beat_cnt(beat_cnt)
    );

    bottom_linear_pipe #(.LANES(1), .STAGES(1), .CNT_W(4)) dut_s (
        .clk(clk), .reset_n(reset_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_m(s_in_m), .in_const_en(s_in_const_en),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_s(s_out_s), .beat_cnt(s_beat_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [62:0] bm(input int n);
        logic [62:0] r;
        r = '0;
        r[n] = 1'b1;
        return r;
    endfunction

    // Row b of the linear map A: output bit b is the parity of M over these indices.
    function automatic logic [62:0] mask_of(input int b);
        case (b)
            7: return bm(61)|bm(48)|bm(60)|bm(54)|bm(49)|bm(55)|bm(51)|bm(52);
            6: return bm(55)|bm(60)|bm(61)|bm(45)|bm(46)|bm(54)|bm(51)|bm(52);
            5: return bm(62)|bm(53)|bm(57)|bm(59)|bm(45)|bm(47)|bm(51)|bm(60);
            4: return bm(61)|bm(48)|bm(60)|bm(49)|bm(55)|bm(45)|bm(46)|bm(54);
            3: return bm(60)|bm(61)|bm(49)|bm(55)|bm(46)|bm(54)|bm(47)|bm(50);
            2: return bm(61)|bm(48)|bm(60)|bm(52)|bm(53)|bm(57)|bm(59)|bm(45)|bm(47)|bm(56)|bm(49)|bm(55);
            1: return bm(49)|bm(60)|bm(61)|bm(50)|bm(58)|bm(52)|bm(53)|bm(57);
            default: return bm(61)|bm(48)|bm(60)|bm(57)|bm(50)|bm(58)|bm(45)|bm(47);
        endcase
    endfunction

    function automatic logic [7:0] ref_byte(input logic [62:0] m, input logic c);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = ^(m & mask_of(b));
        return r ^ (c ? 8'h63 : 8'h00);
    endfunction

    function automatic logic [SW-1:0] ref_word(input logic [MW-1:0] m, input logic c);
        logic [SW-1:0] r;
        for (int i = 0; i < LANES; i++) r[8*i +: 8] = ref_byte(m[63*i +: 63], c);
        return r;
    endfunction

    function automatic logic [MW-1:0] rand_m();
        logic [MW-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = (r << 32) | MW'($urandom);
        return r;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got unexpected event, expected none", name);
    endtask

    // ---------------- scoreboard monitor (samples 1 time unit before the rising edge) ----------------
    logic          prev_stall = 1'b0;
    logic [SW-1:0] prev_s = '0;

    always begin
        @(negedge clk);
        #4;
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", 32'(out_valid), 32'd1);
                check("stall_hold_data", out_s, prev_s);
            end
            check("beat_cnt", 32'(beat_cnt), 32'(exp_cnt & 16'hFFFF));
            if (in_valid && in_ready) exp_q.push_back(ref_word(in_m, in_const_en));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) fail_now("spurious_out");
                else check("scoreboard_out_s", out_s, exp_q.pop_front());
                exp_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_s     = out_s;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic test_b2b();
        int first = -1;
        int last  = -1;
        int cnt   = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
                cnt++;
            end
            if (cyc < 8) begin
                in_valid = 1'b1; in_m = '1; in_const_en = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        check("b2b_count", 32'(cnt), 32'd8);
        check("b2b_first_latency", 32'(first), 32'(STAGES));
        check("b2b_consecutive", 32'(last - first), 32'd7);
        check("b2b_beat_cnt", 32'(beat_cnt), 32'd8);
    endtask

    task automatic test_table();
        int lat;
        for (int t = 0; t < NT; t++) begin
            @(negedge clk);
            in_valid = 1'b1; in_m = tbl[t].m; in_const_en = tbl[t].c; out_ready = 1'b1;
            lat = 0;
            while (lat < 10) begin
                @(negedge clk);
                in_valid = 1'b0;
                lat++;
                if (out_valid) break;
            end
            check($sformatf("tbl%0d_latency", t), 32'(lat), 32'(STAGES));
            check($sformatf("tbl%0d_out_s", t), out_s, tbl[t].exp);
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] held;
        held = '0;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k <= 2) begin
                in_m = rand_m(); in_const_en = 1'($urandom_range(1));
            end
            in_valid = 1'b1;
            #1;
            check($sformatf("bp_in_ready_%0d", k), 32'(in_ready), (k < 2) ? 32'd1 : 32'd0);
            if (k >= 2) check($sformatf("bp_out_valid_%0d", k), 32'(out_valid), 32'd1);
            if (k == 2) held = out_s;
            if (k >= 3) check($sformatf("bp_out_s_stable_%0d", k), out_s, held);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("bp_drained_queue", 32'(exp_q.size()), 32'd0);
        check("bp_drained_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic test_reset_flight();
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_m = rand_m(); in_const_en = 1'b1;
        @(negedge clk);
        in_m = rand_m();
        @(negedge clk);
        in_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("rst_flight_out_valid", 32'(out_valid), 32'd0);
        check("rst_flight_out_s", out_s, '0);
        check("rst_flight_beat_cnt", 32'(beat_cnt), 32'd0);
        exp_q.delete();
        exp_cnt = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rst_no_stale_%0d", k), 32'(out_valid), 32'd0);
        end
    endtask

    task automatic test_random(input int n);
        int   sent = 0;
        int   cyc  = 0;
        logic acc  = 1'b0;
        in_valid = 1'b0;
        while (cyc < 60000) begin
            @(negedge clk);
            if (sent == n && exp_q.size() == 0) break;
            cyc++;
            if (!(in_valid && !acc)) begin
                in_m = rand_m();
                in_const_en = 1'($urandom_range(1));
                in_valid = (sent < n) && ($urandom_range(3) != 0);
            end
            out_ready = ($urandom_range(3) != 0);
            #4;
            acc = in_valid && in_ready;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        check("random_beats_sent", 32'(sent), 32'(n));
        check("random_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic test_small_wrap();
        int outs = 0;
        s_out_ready = 1'b1;
        for (int cyc = 0; cyc < 22; cyc++) begin
            @(negedge clk);
            if (s_out_valid) begin
                outs++;
                if (s_q.size() == 0) fail_now("small_spurious_out");
                else check("small_out_s", 32'(s_out_s), 32'(s_q.pop_front()));
            end
            if (cyc == 1) check("small_latency", 32'(s_out_valid), 32'd1);
            if (cyc < 17) begin
                s_in_valid = 1'b1;
                s_in_m = 63'(rand_m());
                s_in_const_en = 1'($urandom_range(1));
                #1;
                check("small_in_ready", 32'(s_in_ready), 32'd1);
                s_q.push_back(ref_byte(s_in_m, s_in_const_en));
            end else begin
                s_in_valid = 1'b0;
            end
        end
        check("small_out_count", 32'(outs), 32'd17);
        check("small_beat_cnt_wrap", 32'(s_beat_cnt), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [MW-1:0] m_lane0;
        logic [MW-1:0] m_lane3;
        m_lane0 = '0; m_lane0[60] = 1'b1;
        m_lane3 = '0; m_lane3[63*3+60] = 1'b1;
        tbl[0] = '{m: '0,      c: 1'b1, exp: 32'h63636363};
        tbl[1] = '{m: '0,      c: 1'b0, exp: 32'h00000000};
        tbl[2] = '{m: m_lane0, c: 1'b1, exp: 32'h6363639C};
        tbl[3] = '{m: m_lane0, c: 1'b0, exp: 32'h000000FF};
        tbl[4] = '{m: '1,      c: 1'b1, exp: 32'h63636363};
        tbl[5] = '{m: '1,      c: 1'b0, exp: 32'h00000000};
        tbl[6] = '{m: m_lane3, c: 1'b1, exp: 32'h9C636363};

        reset_n = 1'b0; in_valid = 1'b0; in_m = '0; in_const_en = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_m = '0; s_in_const_en = 1'b0; s_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_s", out_s, '0);
        check("reset_beat_cnt", 32'(beat_cnt), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;

        test_b2b();
        test_table();
        test_backpressure();
        test_reset_flight();
        test_random(10000);
        test_small_wrap();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bottom_linear_pipe.md
Name: bottom_linear_pipe

Overview:
- Multi-lane, pipelined successor to the combinational forward bottom linear transform of the depth-16 AES S-box.
- Each lane maps a 63-bit M vector (M0–M62 indexing) to an 8-bit S byte using the same L0–L29 XOR/XNOR network, then registers the result.
- Adds valid/ready flow control, 1- or 2-stage pipelining, a per-beat affine-constant enable for masked shares, and a beat counter.
- Sits between the shared nonlinear middle stage and the round datapath byte bus.

Parameters:
- LANES, 4, number of parallel S-box lanes (1–16).
- STAGES, 2, pipeline depth. 1 = S registered only. 2 = L[29:0] registered, then S registered.
- CNT_W, 16, width of the output beat counter.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, block can accept a beat this cycle.
- in_m, input, 63*LANES, lane i occupies in_m[63*i+62 : 63*i].
- in_const_en, input, 1, 1 = apply the XNOR constant terms (full affine map); 0 = linear part only (S ^ 8'h63).
- out_valid, output, 1, output beat valid.
- out_ready, input, 1, downstream accepts the beat.
- out_s, output, 8*LANES, lane i occupies out_s[8*i+7 : 8*i].
- beat_cnt, output, CNT_W, number of completed output handshakes.

Behaviour:
- Reset (async assert, sync deassert assumed upstream): all stage valids = 0, out_valid = 0, out_s = 0, beat_cnt = 0, internal L registers = 0. Reset mid-flight discards all in-flight beats; no partial output.
- Transfer rules: input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Per-lane function: S = A·M ^ (in_const_en ? 8'h63 : 8'h00).
  - A is the GF(2) linear map of the existing forward bottom transform.
  - The 8'h63 equals the XNOR contributions on S[6], S[5], S[1], S[0].
  - in_const_en travels with its beat through every stage.
- Pipeline: each stage k has a valid bit v[k] and a data register.
  - Stage k loads when ~v[k] | advance[k+1]; the last stage advances on the output transfer.
  - in_ready = ~v[0] | advance[1]. This is a combinational path from out_ready; accepted.
- Latency: beat accepted in cycle t appears with out_valid in cycle t+STAGES when there is no backpressure.
- Throughput: 1 beat/cycle sustained while out_ready = 1.
- Stall: while out_valid & ~out_ready, out_s and the constant choice are held bit-stable. Upstream stages fill; no beat is dropped or duplicated.
- Full condition: all v[k] = 1 and out_ready = 0, giving in_ready = 0.
- Simultaneous events: accept and emit in the same cycle is legal when full and out_ready = 1. A stage refilled in the same cycle it drains stays valid.
- beat_cnt: increments by 1 on each output transfer; wraps from 2^CNT_W-1 to 0; no saturation.
- Lanes are independent. No cross-lane logic. All lanes share one valid/ready.
- in_m and in_const_en are ignored when in_valid = 0.

Test Plan:
- All lanes in_m = 0, in_const_en = 1, out_ready = 1 → every lane out_s byte = 8'h63, exactly STAGES cycles after acceptance. With in_const_en = 0 → 8'h00.
- Lane 0 in_m = 1<<60 (only M60 set), others 0, in_const_en = 1 → lane 0 = 8'h9C, others 8'h63. With in_const_en = 0 → lane 0 = 8'hFF.
- All lanes in_m = all ones, in_const_en = 1 → every byte 8'h63 (A·1 = 0). Back-to-back 8 beats with out_ready = 1 → 8 outputs in consecutive cycles, beat_cnt = 8.
- Backpressure: out_ready = 0 for 5 cycles with in_valid = 1 → in_ready falls after STAGES beats are accepted; out_s is stable throughout. Release → beats emerge in order with no loss; random M compared against a golden model over 10k beats with random valid/ready.
- Reset asserted while 2 beats are in flight → out_valid = 0, out_s = 0, beat_cnt = 0 immediately (asynchronously). No stale beat appears after release.
- CNT_W = 4, 17 output transfers → beat_cnt reads 1 (wrap verified).
